// File: rtl/mext_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mext_sequencer_if
// Description : Execute-side and M-unit-side signal bundle for mext_sequencer.
// Revision    : 1.0
// ============================================================================
interface mext_sequencer_if #(
    parameter int XLEN = 32
);
    logic            mul_use;
    logic [2:0]      mul_opcode;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            flush;
    logic            start;
    logic [2:0]      unit_op;
    logic [XLEN-1:0] unit_a;
    logic [XLEN-1:0] unit_b;
    logic            unit_abort;
    logic            done;
    logic [XLEN-1:0] unit_hi;
    logic [XLEN-1:0] unit_lo;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result_m;
    logic            timeout_err;

    modport slave (
        input  mul_use, mul_opcode, operand1, operand2, flush, done, unit_hi, unit_lo,
        output start, unit_op, unit_a, unit_b, unit_abort, stall, result_valid,
               result_m, timeout_err
    );

    modport master (
        output mul_use, mul_opcode, operand1, operand2, flush, done, unit_hi, unit_lo,
        input  start, unit_op, unit_a, unit_b, unit_abort, stall, result_valid,
               result_m, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mext_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mext_sequencer
// Description : Execute-stage controller for the shared iterative mul/div unit.
// Revision    : 1.0
// ============================================================================
module mext_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int XLEN    = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mext_sequencer_if.slave   bus
);
    localparam int            CW          = $clog2(TIMEOUT) + 1;
    localparam logic [2:0]    c_OP_MUL    = 3'b000;
    localparam logic [2:0]    c_CLS_MULSS = 3'd0;
    localparam logic [2:0]    c_CLS_MULSU = 3'd1;
    localparam logic [2:0]    c_CLS_MULUU = 3'd2;
    localparam logic [2:0]    c_CLS_DIVS  = 3'd3;
    localparam logic [2:0]    c_CLS_DIVU  = 3'd4;
    localparam logic [XLEN-1:0] c_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] class_of(input logic [2:0] op);
        logic [2:0] cls;
        case (op)
            3'b000, 3'b001: cls = c_CLS_MULSS;
            3'b010:         cls = c_CLS_MULSU;
            3'b011:         cls = c_CLS_MULUU;
            3'b100, 3'b110: cls = c_CLS_DIVS;
            default:        cls = c_CLS_DIVU;
        endcase
        return cls;
    endfunction

    // MUL and quotients take the low word; high products and remainders the high word
    function automatic logic [XLEN-1:0] select_word(input logic [2:0] op,
                                                    input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo);
        return (op == 3'b000 || op == 3'b100 || op == 3'b101) ? lo : hi;
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_start;
    logic            r_abort;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_timeout_err;
    logic            r_c_valid;
    logic [2:0]      r_c_cls;
    logic [XLEN-1:0] r_c_a;
    logic [XLEN-1:0] r_c_b;
    logic [XLEN-1:0] r_c_hi;
    logic [XLEN-1:0] r_c_lo;

    logic            w_is_div;
    logic            w_is_rem;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;
    logic [2:0]      w_cls;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_res;
    logic [XLEN-1:0] w_unit_res;
    logic            w_active;

    assign w_is_div   = bus.mul_opcode[2];
    assign w_is_rem   = bus.mul_opcode[2] & bus.mul_opcode[1];
    assign w_div0     = w_is_div & (bus.operand2 == '0);
    assign w_ovf      = w_is_div & ~bus.mul_opcode[0] & (bus.operand1 == c_MIN_INT)
                        & (bus.operand2 == '1);
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_res = w_div0 ? (w_is_rem ? bus.operand1 : '1)
                               : (w_is_rem ? '0 : c_MIN_INT);

    // Low product word is identical for every signedness, so MUL may reuse any mul class
    assign w_cls      = class_of(bus.mul_opcode);
    assign w_hit      = r_c_valid & (bus.operand1 == r_c_a) & (bus.operand2 == r_c_b)
                        & (((bus.mul_opcode == c_OP_MUL) & (r_c_cls <= c_CLS_MULUU))
                           | (w_cls == r_c_cls));
    assign w_hit_res  = select_word(bus.mul_opcode, r_c_hi, r_c_lo);
    assign w_unit_res = select_word(r_op, bus.unit_hi, bus.unit_lo);
    assign w_active   = (r_state == S_START) | (r_state == S_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_start       <= 1'b0;
            r_abort       <= 1'b0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_timeout_err <= 1'b0;
            r_c_valid     <= 1'b0;
            r_c_cls       <= '0;
            r_c_a         <= '0;
            r_c_b         <= '0;
            r_c_hi        <= '0;
            r_c_lo        <= '0;
        end else begin
            r_start <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.mul_use) begin
                        r_op <= bus.mul_opcode;
                        r_a  <= bus.operand1;
                        r_b  <= bus.operand2;
                        if (w_special) begin
                            r_result <= w_spec_res;
                            r_state  <= S_DONE;
                        end else if (w_hit) begin
                            r_result <= w_hit_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= bus.flush ? S_IDLE : S_BUSY;
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else if (bus.done) begin
                        r_c_valid <= 1'b1;
                        r_c_cls   <= class_of(r_op);
                        r_c_a     <= r_a;
                        r_c_b     <= r_b;
                        r_c_hi    <= bus.unit_hi;
                        r_c_lo    <= bus.unit_lo;
                        r_result  <= w_unit_res;
                        r_state   <= S_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_abort       <= 1'b1;
                        r_result      <= '0;
                        r_state       <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.start        = r_start;
    assign bus.unit_op      = r_op;
    assign bus.unit_a       = r_a;
    assign bus.unit_b       = r_b;
    // Flush kills the unit in the same cycle; a timeout abort follows one cycle later
    assign bus.unit_abort   = r_abort | (bus.flush & w_active & ~rst);
    assign bus.stall        = bus.mul_use & (r_state != S_DONE) & ~bus.flush;
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.result_m     = r_result;
    assign bus.timeout_err  = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_mext_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mext_sequencer
// Description : Scoreboard bench for mext_sequencer with a behavioural M-unit.
// Revision    : 1.0
// ============================================================================
module tb_mext_sequencer;
    localparam int TIMEOUT = 40;
    localparam int ITER    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mext_sequencer_if #(.XLEN(32)) bus ();

    mext_sequencer #(.TIMEOUT(TIMEOUT), .XLEN(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_start  = 0;
    bit          withhold = 1'b0;
    logic [5:0]  u_cnt;
    logic [31:0] exp_q[$];
    logic        abort_at_done;
    logic        terr_at_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: returns {remainder/high, quotient/low}
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0]        sa, sb, ua, ub;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        qa = a;
        qb = b;
        case (op)
            3'b000, 3'b001: return sa * sb;
            3'b010:         return sa * ub;
            3'b011:         return ua * ub;
            3'b100, 3'b110: return (b == 0) ? 64'h0 : {32'(qa % qb), 32'(qa / qb)};
            default:        return (b == 0) ? 64'h0 : {a % b, a / b};
        endcase
    endfunction

    function automatic logic [31:0] ref_m(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] r;
        if (op[2] && b == 32'h0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        r = calc(op, a, b);
        return (op == 3'b000 || op == 3'b100 || op == 3'b101) ? r[31:0] : r[63:32];
    endfunction

    // Behavioural M-unit: done arrives ITER cycles after start
    always @(posedge clk) begin
        if (rst || bus.unit_abort) u_cnt <= '0;
        else if (bus.start)        u_cnt <= 6'(ITER);
        else if (u_cnt != 0)       u_cnt <= u_cnt - 6'd1;
    end
    assign bus.done = (u_cnt == 6'd1) && !withhold;
    assign {bus.unit_hi, bus.unit_lo} = calc(bus.unit_op, bus.unit_a, bus.unit_b);

    always @(negedge clk) begin
        if (bus.start) n_start++;
        if (!rst && bus.result_valid) begin
            if (exp_q.size() == 0) check_eq("unexpected_valid", 32'd1, 32'd0);
            else                   check_eq("result", bus.result_m, exp_q.pop_front());
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int starts,
                         input string tag);
        int n;
        int nst;
        n = 0;
        nst = 0;
        n_start = 0;
        bus.mul_use    = 1'b1;
        bus.mul_opcode = op;
        bus.operand1   = a;
        bus.operand2   = b;
        exp_q.push_back(exp);
        do begin
            @(negedge clk);
            n++;
            if (bus.stall) nst++;
        end while (!bus.result_valid && n < 200);
        abort_at_done = bus.unit_abort;
        terr_at_done  = bus.timeout_err;
        check_eq({tag, "_lat"}, 32'(n), 32'(lat));
        check_eq({tag, "_stall"}, 32'(nst), 32'(lat - 1));
        check_eq({tag, "_starts"}, 32'(n_start), 32'(starts));
        @(posedge clk);
        #1;
        bus.mul_use = 1'b0;
    endtask

    initial begin
        bus.mul_use    = 1'b0;
        bus.mul_opcode = 3'b000;
        bus.operand1   = 32'h0;
        bus.operand2   = 32'h0;
        bus.flush      = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_outs", {27'b0, bus.start, bus.unit_abort, bus.result_valid,
                                bus.stall, bus.timeout_err}, 32'h0);
        check_eq("reset_result", bus.result_m, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(3'b000, 32'd7, 32'd6, 32'h0000_002A, ITER + 3, 1, "mul7x6");
        issue(3'b100, 32'h64, 32'h0, 32'hFFFF_FFFF, 2, 0, "div0");
        issue(3'b110, 32'h64, 32'h0, 32'h0000_0064, 2, 0, "rem0");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0, "divovf");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 0, "removf");
        issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, ITER + 3, 1, "divu_big");
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, ITER + 3, 1, "mulh");
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 2, 0, "mul_hit");
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ITER + 3, 1, "mulhu_miss");
        issue(3'b101, 32'd100, 32'd7, 32'd14, ITER + 3, 1, "divu");
        issue(3'b111, 32'd100, 32'd7, 32'd2, 2, 0, "remu_hit");
        issue(3'b110, 32'd100, 32'd7, 32'd2, ITER + 3, 1, "rem_miss");
        issue(3'b100, 32'd100, 32'd7, 32'd14, 2, 0, "div_hit");
        issue(3'b010, 32'hFFFF_FFFE, 32'd3, ref_m(3'b010, 32'hFFFF_FFFE, 32'd3), ITER + 3, 1, "mulhsu");
        issue(3'b001, 32'hFFFF_FFFE, 32'd3, ref_m(3'b001, 32'hFFFF_FFFE, 32'd3), ITER + 3, 1, "mulh_miss");

        // Flush in BUSY cycle 10 of an uncached op
        n_start = 0;
        bus.mul_use    = 1'b1;
        bus.mul_opcode = 3'b011;
        bus.operand1   = 32'd3;
        bus.operand2   = 32'd4;
        repeat (11) @(negedge clk);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check_eq("flush_abort", {31'b0, bus.unit_abort}, 32'd1);
        check_eq("flush_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.mul_use = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("flush_quiet", {30'b0, bus.result_valid, bus.unit_abort}, 32'd0);
        end
        check_eq("flush_starts", 32'(n_start), 32'd1);
        @(posedge clk);
        #1;
        issue(3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 2, 0, "flush_cache_kept");
        issue(3'b000, 32'd5, 32'd5, 32'd25, ITER + 3, 1, "mul_after_flush");

        // Unit never completes
        withhold = 1'b1;
        issue(3'b000, 32'd9, 32'd9, 32'h0, TIMEOUT + 3, 1, "timeout");
        check_eq("timeout_err_set", {31'b0, terr_at_done}, 32'd1);
        check_eq("timeout_abort", {31'b0, abort_at_done}, 32'd1);
        withhold = 1'b0;
        issue(3'b000, 32'd9, 32'd9, 32'd81, ITER + 3, 1, "after_timeout");
        check_eq("timeout_err_sticky", {31'b0, bus.timeout_err}, 32'd1);

        // Reset in the middle of BUSY
        bus.mul_use    = 1'b1;
        bus.mul_opcode = 3'b000;
        bus.operand1   = 32'd11;
        bus.operand2   = 32'd11;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mul_use = 1'b0;
        @(negedge clk);
        check_eq("rst_no_abort", {31'b0, bus.unit_abort}, 32'd0);
        @(negedge clk);
        check_eq("rst_outs", {27'b0, bus.start, bus.unit_abort, bus.result_valid,
                              bus.stall, bus.timeout_err}, 32'h0);
        check_eq("rst_result", bus.result_m, 32'h0);
        check_eq("rst_unit_a", bus.unit_a, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(3'b000, 32'd9, 32'd9, 32'd81, ITER + 3, 1, "cache_cleared");

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mext_sequencer.md
Name: mext_sequencer

Overview:
- Controller between the Execute stage and the shared iterative M-extension unit (shift-add multiplier / restoring divider).
- Accepts one M-instruction at a time and stalls the pipeline while the unit iterates.
- Resolves RISC-V divide special cases without starting the unit.
- Reuses the previous 64-bit result when a paired op has identical operands (MULH→MUL, DIV→REM).

Parameters:
- TIMEOUT, 40, max cycles in BUSY before forcing completion and flagging an error.
- XLEN, 32, operand width (only 32 supported).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mul_use  in  1  Execute holds a valid M-instruction (level, held until result_valid)
- mul_opcode  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand1  in  32  rs1 value
- operand2  in  32  rs2 value
- flush  in  1  Execute-stage kill (branch mispredict/trap)
- start  out  1  one-cycle pulse launching the unit
- unit_op  out  3  registered copy of mul_opcode driven to the unit
- unit_a  out  32  registered rs1 to the unit
- unit_b  out  32  registered rs2 to the unit
- unit_abort  out  1  one-cycle pulse resetting the unit's iteration
- done  in  1  unit completion pulse
- unit_hi  in  32  product[63:32] (mul) or remainder (div)
- unit_lo  in  32  product[31:0] (mul) or quotient (div)
- stall  out  1  freeze IF/ID/EX
- result_valid  out  1  result presented this cycle
- result_m  out  32  selected 32-bit result
- timeout_err  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- States: IDLE, START, BUSY, DONE.
- All registered outputs, the cache valid bit and timeout_err reset to 0; the state resets to IDLE. rst mid-operation returns to IDLE next edge with no abort pulse; the unit shares rst.
- stall = mul_use & (state != DONE) & ~flush (combinational). result_valid = (state == DONE).
- IDLE with mul_use=1 captures opcode and operands, then selects one of three paths:
  - special: div/rem with operand2=0 → quotient 0xFFFFFFFF, remainder operand1. Signed div/rem with operand1=0x80000000 and operand2=0xFFFFFFFF → quotient 0x80000000, remainder 0. Goes to DONE; no start.
  - cache hit: goes to DONE; no start.
  - otherwise: goes to START.
- START: start=1 for exactly one cycle, then BUSY. The cycle counter clears.
- BUSY: on done, latch {unit_hi, unit_lo}, update the cache and go to DONE. The counter increments each cycle. When counter == TIMEOUT-1 without done: set timeout_err, pulse unit_abort, result_m=0, go to DONE.
- DONE lasts one cycle: result_valid=1, stall=0, then IDLE. A back-to-back mul_use in the following IDLE cycle is treated as a new instruction.
- Result select:
  - MUL → lo.
  - MULH/MULHSU/MULHU → hi.
  - DIV/DIVU → lo (quotient).
  - REM/REMU → hi (remainder).
- Cache holds a valid bit, op class, operand1, operand2 and 64-bit result. Op class is one of: MULSS, MULSU, MULUU, DIVS, DIVU.
- Cache hit requires valid, equal operands, and one of:
  - the requested op is MUL and the cached class is any MUL class (low word is signedness-independent);
  - the requested class equals the cached class.
- Cache writes only on a done in BUSY; the special path does not write it.
- flush in START or BUSY: unit_abort=1 that cycle, cache unchanged, IDLE next cycle, no result_valid. flush in IDLE/DONE: no effect beyond stall gating.
- done arriving in IDLE/START/DONE is ignored.
- Latency:
  - special/hit: issue cycle + 1 → result_valid at cycle 2.
  - normal: 2 + unit iterations + 1.

Test Plan:
- MUL 7×6, unit returns done after 32 cycles with lo=42 → one start pulse; stall high 34 cycles; result_m=0x0000002A for exactly 1 cycle.
- DIV 0x00000064/0 → no start; result_valid on cycle 2 with 0xFFFFFFFF. REM 0x00000064/0 → 0x00000064. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same → 0.
- MULH 0xFFFFFFFF×0xFFFFFFFF (hi=0, lo=1) then MUL with same operands → second op issues no start; result_m=1 on cycle 2. A following MULHU with same operands → cache miss, start issued.
- DIVU 100/7 then REMU 100/7 → REMU hits with result 2. REM (signed) 100/7 → miss.
- flush during BUSY cycle 10 → unit_abort 1 cycle, no result_valid, next MUL re-starts normally. rst asserted in BUSY → all outputs 0 next cycle.
- done withheld → timeout_err=1 at BUSY cycle TIMEOUT, result_m=0, stall released, timeout_err stays 1 until rst.
